dpram_fifo_ctrl: RTL and testbench

DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

---
 rtl/dpram_fifo_ctrl_if.sv | 53 +++++
 rtl/dpram_fifo_ctrl.sv | 86 ++++++++
 tb/tb_dpram_fifo_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dpram_fifo_ctrl_if.sv
// Bus bundle between the FIFO controller, its user and the dual-port RAM.
// DPRAM_FIFO_CTRL_ERR_FLAG_EN adds the sticky overflow/underflow flags.
interface dpram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  push;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  ram_wen;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_d_in;
  logic                  ram_ren;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_d_out;
`ifdef DPRAM_FIFO_CTRL_ERR_FLAG_EN
  logic                  overflow;
  logic                  underflow;
`endif

  // Handshake: a request is taken on a rising edge when push (pop) is high and
  // full (empty) is low; rd_valid marks rd_data exactly one cycle after a taken pop.
`ifdef DPRAM_FIFO_CTRL_ERR_FLAG_EN
  modport slave (
    input  push, wr_data, pop, ram_d_out,
    output rd_data, rd_valid, full, empty, count,
    output ram_wen, ram_waddr, ram_d_in, ram_ren, ram_raddr,
    output overflow, underflow
  );
  modport master (
    output push, wr_data, pop, ram_d_out,
    input  rd_data, rd_valid, full, empty, count,
    input  ram_wen, ram_waddr, ram_d_in, ram_ren, ram_raddr,
    input  overflow, underflow
  );
`else
  modport slave (
    input  push, wr_data, pop, ram_d_out,
    output rd_data, rd_valid, full, empty, count,
    output ram_wen, ram_waddr, ram_d_in, ram_ren, ram_raddr
  );
  modport master (
    output push, wr_data, pop, ram_d_out,
    input  rd_data, rd_valid, full, empty, count,
    input  ram_wen, ram_waddr, ram_d_in, ram_ren, ram_raddr
  );
`endif
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO pointer/occupancy controller around an external dual-port RAM with one-cycle read latency.
// Optional sticky error flags are enabled by defining DPRAM_FIFO_CTRL_ERR_FLAG_EN.
module dpram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  dpram_fifo_ctrl_if.slave   bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  rd_valid_q;
  logic                  full, empty;
  logic                  push_acc, pop_acc;

  // Flags come only from registered occupancy, so push/pop never loop back into them.
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // Gating with rst_n keeps the RAM ports quiet while reset is held.
  assign push_acc = rst_n & bus.push & ~full;
  assign pop_acc  = rst_n & bus.pop  & ~empty;

  always_comb begin
    wptr_d  = wptr_q + ADDR_WIDTH'(push_acc);
    rptr_d  = rptr_q + ADDR_WIDTH'(pop_acc);
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_valid_q <= pop_acc;
    end
  end

  assign bus.ram_wen   = push_acc;
  assign bus.ram_waddr = wptr_q;
  assign bus.ram_d_in  = bus.wr_data;
  assign bus.ram_ren   = pop_acc;
  assign bus.ram_raddr = rptr_q;
  assign bus.rd_data   = bus.ram_d_out;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;

`ifdef DPRAM_FIFO_CTRL_ERR_FLAG_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (bus.push & full);
    underflow_d = underflow_q | (bus.pop & empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Randomized scoreboard bench for dpram_fifo_ctrl with a behavioural queue model and a RAM model.
module tb_dpram_fifo_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst_n;

  dpram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dual-port RAM with registered read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_d_in;
    if (bus.ram_ren) bus.ram_d_out <= mem[bus.ram_raddr];
  end

  // reference model and scoreboard state
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  int  wr_total;
  int  rd_total;
  bit  m_ovf;
  bit  m_unf;
  int  n_pass;
  int  n_total;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    wr_total = 0;
    rd_total = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  task automatic check_flags();
`ifdef DPRAM_FIFO_CTRL_ERR_FLAG_EN
    chk("overflow", bus.overflow, m_ovf);
    chk("underflow", bus.underflow, m_unf);
`endif
  endtask

  // one clock cycle of stimulus with pre-edge checks and post-edge model update
  task automatic cycle(input bit p, input logic [DW-1:0] d, input bit q);
    bit p_acc;
    bit q_acc;
    @(negedge clk);
    bus.push    = p;
    bus.wr_data = d;
    bus.pop     = q;
    #1;
    p_acc = p && (model_q.size() < DEPTH);
    q_acc = q && (model_q.size() > 0);
    chk("count", bus.count, model_q.size());
    chk("full", bus.full, model_q.size() == DEPTH);
    chk("empty", bus.empty, model_q.size() == 0);
    chk("ram_wen", bus.ram_wen, p_acc);
    chk("ram_ren", bus.ram_ren, q_acc);
    if (p_acc) begin
      chk("ram_waddr", bus.ram_waddr, wr_total % DEPTH);
      chk("ram_d_in", bus.ram_d_in, d);
    end
    if (q_acc) chk("ram_raddr", bus.ram_raddr, rd_total % DEPTH);
    check_flags();
    @(posedge clk);
    if (q_acc) begin
      exp_q.push_back(model_q.pop_front());
      rd_total++;
    end
    if (p_acc) begin
      model_q.push_back(d);
      wr_total++;
    end
    if (p && !p_acc) m_ovf = 1'b1;
    if (q && !q_acc) m_unf = 1'b1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n    = 1'b0;
      bus.push = 1'($urandom_range(0, 1));
      bus.pop  = 1'($urandom_range(0, 1));
      #1;
      chk("rst_ram_wen", bus.ram_wen, 1'b0);
      chk("rst_ram_ren", bus.ram_ren, 1'b0);
      @(posedge clk);
      model_reset();
    end
    @(negedge clk);
    rst_n    = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    #1;
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    check_flags();
  endtask

  // monitor: every presented word must match the oldest expected one
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) chk("rd_valid_unexpected", 1'b1, 1'b0);
        else chk("rd_data", bus.rd_data, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        chk("rd_valid_missing", 1'b0, 1'b1);
        exp_q.delete();
      end
    end
  end

  initial begin
    n_pass      = 0;
    n_total     = 0;
    rst_n       = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.wr_data = '0;
    model_reset();

    do_reset(2);

    // single push, then read it back
    cycle(1'b1, 32'hDEADBEEF, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // fill to full with incrementing data, one extra push rejected
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0);

    // drain from full, one extra pop rejected
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // steady state at count 5 with wrapping pointers
    do_reset(1);
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 2000; i++) cycle(1'b1, $urandom, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

    // simultaneous push and pop while empty
    cycle(1'b1, 32'h1234_5678, 1'b1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // random mixed traffic, biased toward filling then draining
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0);
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 800; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

    // reset right after a pop taken at count 10
    do_reset(1);
    for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 1'b0);
    cycle(1'b0, '0, 1'b1);
    do_reset(1);

    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
